alu_seq_unit: RTL
=================

# alu_seq_unit

Parametrised, handshaked successor to the team's combinational 32-bit ALU. It registers operands and results, adds a multi-cycle shift-add multiplier, and reports a full signed/unsigned flag set. It sits between the operand-fetch stage and writeback, using valid/ready on both sides. It holds one operation in flight and supports back-to-back single-cycle operations at one per clock.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived; do not override).

Ports. One clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept this cycle.
- `operand_a`  in  WIDTH  first operand.
- `operand_b`  in  WIDTH  second operand; shift amount in `[SHW-1:0]` for shifts.
- `alu_op`  in  4  opcode.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  operation result.
- `carry`  out  1  unsigned carry-out (ADD); no-borrow, A ≥ B unsigned (SUB); else 0.
- `overflow`  out  1  signed overflow (ADD/SUB); upper product half non-zero (MUL); else 0.
- `zero`  out  1  result == 0.
- `negative`  out  1  result[WIDTH-1].
- `equal`  out  1  operand_a == operand_b (captured operands).
- `illegal`  out  1  opcode not defined below.

## Operation
- Opcodes:
  - 0000 NOP: result 0.
  - 0001 ADD.
  - 0010 SUB: raw two's complement, no magnitude conversion.
  - 0101 AND, 0110 OR, 0111 NOT a, 1000 XOR: all bitwise.
  - 1001 SHL and 1010 SHR (logical): a shifted by b[SHW-1:0].
  - 1011 MOV: a.
  - 1100 MUL: low WIDTH bits of the unsigned product.
  - All others: result 0, illegal=1, other flags 0.
- A handshake occurs when `in_valid` and `in_ready` are both high. Operands and opcode are captured into internal registers. Input changes after acceptance have no effect.
- FSM states IDLE, EXEC, DONE.
  - IDLE: on accept of a non-MUL op → DONE. On accept of MUL → EXEC.
  - EXEC: one shift-add iteration per cycle, WIDTH iterations, then → DONE.
  - DONE: `out_valid`=1. If `out_ready` and a new accept occur in the same cycle → DONE (non-MUL) or EXEC (MUL). If `out_ready` only → IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). The combinational path from `out_ready` to `in_ready` is intentional.
- Add and subtract use a WIDTH+1-bit internal sum for carry. Overflow is computed on signs: ADD when a,b signs match and the result sign differs; SUB when a,b signs differ and the result sign ≠ a's sign.
- The multiplier keeps a 2·WIDTH-bit accumulator. overflow = |acc[2W-1:W].
- `result` and all flags are registered and stable for as long as `out_valid` is high and unacknowledged.

## Timing
- Reset (`rst_n` low at a rising edge): state=IDLE, `out_valid`=0, and `result` and all flags = 0. `in_ready` is forced 0 while `rst_n` is low and is 1 in the first cycle after release.
- Non-MUL latency: accepted at edge N → `out_valid` high after edge N+1 (1 cycle).
- MUL latency: accepted at edge N → `out_valid` after edge N+WIDTH+1 (33 cycles for WIDTH=32). `in_ready`=0 throughout EXEC.
- Throughput: one non-MUL op per cycle while `out_ready` is held high.
- Backpressure: with `out_ready` low in DONE, the result is held indefinitely and `in_ready`=0.
- Reset mid-EXEC or mid-DONE: the operation is discarded, no `out_valid` pulse is produced, and the state returns to IDLE.
- Shift by 0 returns a unchanged. Shift amount bits above SHW are ignored.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_MUL`);
  - the state enum `alu_state_t` {IDLE, EXEC, DONE};
  - the latency constant `MUL_CYCLES = WIDTH`.
- One sub-module, `alu_mul_seq`: a parametrised shift-add multiplier with `start`, `busy` and `done`, and a 2·WIDTH-bit product. The top level owns the FSM, the combinational ops, the flags and the handshake.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → result 0, carry=1, zero=1, overflow=0, `out_valid` one cycle after accept.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow=1, negative=1, carry=0.
- SUB 3 − 5 → result 0xFFFFFFFE, carry=0, negative=1. SUB 5 − 5 → result 0, equal=1, zero=1, carry=1.
- MUL 0x00010000 × 0x00010000 → result 0, overflow=1, `out_valid` 33 cycles after accept. MUL 7 × 6 → 42, overflow=0.
- Back-to-back XOR, SHL (a=1, b=31 → 0x80000000), opcode 1111 with `out_ready` high → three results on consecutive cycles; the third has illegal=1 and result 0. Then hold `out_ready` low for 5 cycles → result stable and `in_ready`=0.
- Assert `rst_n` low for one cycle at cycle 10 of a MUL → no `out_valid`, all outputs 0, and `in_ready`=1 the cycle after release.

Source files
------------

// File: rtl/alu_pkg.sv
package alu_pkg;

  localparam int unsigned ALU_WIDTH  = 32;
  localparam int unsigned MUL_CYCLES = ALU_WIDTH;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1001;
  localparam logic [3:0] OP_SHR = 4'b1010;
  localparam logic [3:0] OP_MOV = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] step;

  // acc holds {upper partial sum, remaining multiplier bits}; each step adds
  // the multiplicand into the upper half when the current LSB is set and
  // shifts the whole accumulator right by one.
  always_comb begin
    partial = acc[0] ? {1'b0, mcand} : '0;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + partial;
    step    = {sum, acc[WIDTH-1:1]};
  end

  // done flags the final iteration; product is the post-iteration value in
  // that same cycle, so the caller can register it on the closing edge.
  always_comb begin
    busy    = busy_q;
    done    = busy_q && (cnt == LAST);
    product = step;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt    <= '0;
      acc    <= {{WIDTH{1'b0}}, b};
      mcand  <= a;
    end else if (busy_q) begin
      acc <= step;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             equal,
  output logic             illegal
);

  alu_state_t state, state_next;

  logic               accept;
  logic               is_mul;
  logic               eq_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   r;
  logic               c;
  logic               ov;
  logic               ill;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  always_comb begin
    in_ready  = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
    out_valid = (state == DONE);
    accept    = in_valid && in_ready;
    is_mul    = (alu_op == OP_MUL);
  end

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (operand_a),
    .b       (operand_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    ov  = 1'b0;
    ill = 1'b0;
    unique case (alu_op)
      OP_NOP: r = '0;
      OP_ADD: begin
        sum = {1'b0, operand_a} + {1'b0, operand_b};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        ov  = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
              (r[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, operand_a} + {1'b0, ~operand_b} + (WIDTH+1)'(1);
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        ov  = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
              (r[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND: r = operand_a & operand_b;
      OP_OR:  r = operand_a | operand_b;
      OP_NOT: r = ~operand_a;
      OP_XOR: r = operand_a ^ operand_b;
      OP_SHL: r = operand_a << operand_b[SHW-1:0];
      OP_SHR: r = operand_a >> operand_b[SHW-1:0];
      OP_MOV: r = operand_a;
      OP_MUL: r = '0;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = is_mul ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (mul_done || !mul_busy) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (accept) begin
          state_next = is_mul ? EXEC : DONE;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      eq_q     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      equal    <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_mul) begin
        result   <= r;
        carry    <= c;
        overflow <= ov;
        zero     <= !ill && (r == '0);
        negative <= r[WIDTH-1];
        equal    <= !ill && (operand_a == operand_b);
        illegal  <= ill;
      end else if (accept) begin
        eq_q <= (operand_a == operand_b);
      end else if ((state == EXEC) && mul_done) begin
        result   <= mul_product[WIDTH-1:0];
        carry    <= 1'b0;
        overflow <= |mul_product[2*WIDTH-1:WIDTH];
        zero     <= (mul_product[WIDTH-1:0] == '0);
        negative <= mul_product[WIDTH-1];
        equal    <= eq_q;
        illegal  <= 1'b0;
      end
    end
  end

endmodule
